load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one outstanding request, completed by ack.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    // The load/store unit issues requests.
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ack
    );

    // The memory answers them.
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: decodes one load or store, checks alignment, performs a
// single word-addressed memory access and returns the extended load result.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [11:0]      operation,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  store_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [XLEN-1:0]  load_data,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    state_t state, state_next;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_load;
    logic            is_store;
    logic            misaligned;
    logic            access_ok;
    logic            accept;
    logic [XLEN-1:0] wdata_next;
    logic [3:0]      wstrb_next;
    logic [XLEN-1:0] load_next;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    logic [2:0]      funct3_q;
    logic [1:0]      lane_q;
    logic            err_q;
    logic            we_q;
    logic [XLEN-1:0] maddr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [XLEN-1:0] load_data_q;
    logic            mem_req_c;

    // Bits [11:10] of the operation word carry no meaning for this unit.
    logic unused_op_bits;
    assign unused_op_bits = &{1'b0, operation[11:10]};

    assign opcode = operation[6:0];
    assign funct3 = operation[9:7];
    assign accept = (state == IDLE) && start;

    // Decode legality, alignment and the store lane formatting of the incoming request.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        wdata_next = '0;
        wstrb_next = 4'b0000;
        if (opcode == OPC_LOAD) begin
            is_load = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        if (opcode == OPC_STORE) begin
            is_store = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata_next = {4{store_data[7:0]}};
                    wstrb_next = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    wdata_next = {2{store_data[15:0]}};
                    wstrb_next = addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_next = store_data;
                    wstrb_next = 4'b1111;
                end
            endcase
        end
    end

    assign access_ok = (is_load || is_store) && !misaligned;

    // Select and extend the addressed lane of the returned read word.
    always_comb begin
        rbyte     = mem.mem_rdata[{lane_q, 3'b000} +: 8];
        rhalf     = mem.mem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_next = {{(XLEN-8){rbyte[7]}}, rbyte};
            3'b001:  load_next = {{(XLEN-16){rhalf[15]}}, rhalf};
            3'b100:  load_next = {{(XLEN-8){1'b0}}, rbyte};
            3'b101:  load_next = {{(XLEN-16){1'b0}}, rhalf};
            default: load_next = mem.mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: errors skip the memory access and go straight to the response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = access_ok ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (mem.mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state alone.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == RESP);
        mem_req_c = (state == ACCESS);
    end

    // Capture the request on acceptance and the load result on the ack of a read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            maddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 4'b0000;
            load_data_q <= '0;
        end else begin
            if (accept) begin
                funct3_q <= funct3;
                lane_q   <= addr[1:0];
                err_q    <= !access_ok;
                if (access_ok) begin
                    maddr_q <= {addr[XLEN-1:2], 2'b00};
                    we_q    <= is_store;
                    wdata_q <= wdata_next;
                    wstrb_q <= wstrb_next;
                end
            end
            if ((state == ACCESS) && mem.mem_ack && !we_q) begin
                load_data_q <= load_next;
            end
        end
    end

    assign err           = err_q;
    assign load_data     = load_data_q;
    assign mem.mem_req   = mem_req_c;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed transactions with a transaction-level
// reference model checked every cycle, plus hand-computed literal expectations.
module tb_load_store_unit;

    localparam int XLEN = 32;

    localparam logic [6:0]  OPC_L  = 7'b0000011;
    localparam logic [6:0]  OPC_S  = 7'b0100011;
    localparam logic [11:0] OP_LB  = {2'b00, 3'b000, OPC_L};
    localparam logic [11:0] OP_LH  = {2'b00, 3'b001, OPC_L};
    localparam logic [11:0] OP_LW  = {2'b00, 3'b010, OPC_L};
    localparam logic [11:0] OP_LBU = {2'b00, 3'b100, OPC_L};
    localparam logic [11:0] OP_LHU = {2'b00, 3'b101, OPC_L};
    localparam logic [11:0] OP_SB  = {2'b00, 3'b000, OPC_S};
    localparam logic [11:0] OP_SH  = {2'b00, 3'b001, OPC_S};
    localparam logic [11:0] OP_SW  = {2'b00, 3'b010, OPC_S};
    localparam logic [11:0] OP_ADD = 12'b000000110011;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [11:0]     operation = '0;
    logic [XLEN-1:0] addr = '0;
    logic [XLEN-1:0] store_data = '0;
    logic            busy;
    logic            done;
    logic            err;
    logic [XLEN-1:0] load_data;

    load_store_unit_if #(.XLEN(XLEN)) mem ();

    load_store_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .operation  (operation),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .mem        (mem.master)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // 0 = rejected, 1 = load, 2 = store
    function automatic int classify(input logic [11:0] op, input logic [31:0] a);
        logic [2:0] f3;
        bit legal_ld, legal_st;
        int size;
        f3 = op[9:7];
        legal_ld = (op[6:0] == OPC_L) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        legal_st = (op[6:0] == OPC_S) && (f3 inside {3'd0, 3'd1, 3'd2});
        size = 1 << f3[1:0];
        if (!(legal_ld || legal_st)) return 0;
        if ((a % size) != 0) return 0;
        return legal_ld ? 1 : 2;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (int'(lane) * 8)) & 32'hFF;
        h = (rd >> (int'(lane[1]) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'd0:    return (sd & 32'hFF) * 32'h01010101;
            3'd1:    return (sd & 32'hFFFF) * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'd0:    return 4'b0001 << lane;
            3'd1:    return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    logic        m_req = 1'b0, m_done = 1'b0, m_err = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ld = '0;
    logic [3:0]  m_wstrb = '0;
    logic [2:0]  m_f3 = '0;
    logic [1:0]  m_lane = '0;

    // Transaction-level model: an outstanding request, a pending response, the last load.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_req <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_we <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_wstrb <= '0; m_ld <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_req) begin
                if (mem.mem_ack) begin
                    m_req  <= 1'b0;
                    m_done <= 1'b1;
                    if (!m_we) m_ld <= load_value(m_f3, m_lane, mem.mem_rdata);
                end
            end else if (!m_done && start) begin
                if (classify(operation, addr) == 0) begin
                    m_done <= 1'b1;
                    m_err  <= 1'b1;
                end else begin
                    m_req   <= 1'b1;
                    m_err   <= 1'b0;
                    m_f3    <= operation[9:7];
                    m_lane  <= addr[1:0];
                    m_addr  <= addr & 32'hFFFFFFFC;
                    m_we    <= (classify(operation, addr) == 2);
                    m_wdata <= (classify(operation, addr) == 2) ? store_wdata(operation[9:7], store_data) : 32'h0;
                    m_wstrb <= (classify(operation, addr) == 2) ? store_wstrb(operation[9:7], addr[1:0]) : 4'b0000;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("busy", busy, m_req | m_done);
        check("done", done, m_done);
        check("err", err, m_err);
        check("load_data", load_data, m_ld);
        check("mem_req", mem.mem_req, m_req);
        if (m_req) begin
            check("mem_addr", mem.mem_addr, m_addr);
            check("mem_we", mem.mem_we, m_we);
            check("mem_wdata", mem.mem_wdata, m_wdata);
            check("mem_wstrb", mem.mem_wstrb, m_wstrb);
        end
        if (done === 1'b1) n_done++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          lat, reqc;
    logic [31:0] fa, fwd, fld;
    logic [3:0]  fst;
    logic        ferr;

    // Issue one request, answer it after `waits` wait cycles, return in the done cycle.
    task automatic do_lsu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int waits, input bit hold);
        int w;
        bit seen;
        operation = op; addr = a; store_data = sd; start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        lat = 0; reqc = 0; w = 0; seen = 0;
        fa = '0; fwd = '0; fst = '0;
        while (done !== 1'b1 && lat < 50) begin
            if (mem.mem_req === 1'b1) begin
                if (!seen) begin
                    fa = mem.mem_addr; fwd = mem.mem_wdata; fst = mem.mem_wstrb;
                end
                seen = 1;
                reqc++;
                if (w == waits) begin
                    mem.mem_ack = 1'b1;
                    mem.mem_rdata = rd;
                end else begin
                    w++;
                end
            end
            step();
            mem.mem_ack = 1'b0;
            lat++;
        end
        check("done_within_budget", done, 1'b1);
        ferr = err;
        fld  = load_data;
    endtask

    typedef struct {
        logic [11:0] op;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          waits;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;

        // Reset state
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mem_req", mem.mem_req, 0);
        check("rst_mem_we", mem.mem_we, 0);
        check("rst_mem_addr", mem.mem_addr, 0);
        check("rst_mem_wdata", mem.mem_wdata, 0);
        check("rst_mem_wstrb", mem.mem_wstrb, 0);
        check("rst_load_data", load_data, 0);
        rst_n = 1'b1;
        step();

        // lw 0x100, no wait: done two cycles after acceptance
        do_lsu(OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        check("lw_addr", fa, 32'h100);
        check("lw_wstrb", fst, 4'b0000);
        check("lw_latency", lat, 1);
        check("lw_reqc", reqc, 1);
        check("lw_data", fld, 32'hDEADBEEF);
        check("lw_err", ferr, 0);
        step();

        // lb / lbu of the top byte
        do_lsu(OP_LB, 32'h103, 32'h0, 32'h80112233, 0, 0);
        check("lb_data", fld, 32'hFFFFFF80);
        step();
        do_lsu(OP_LBU, 32'h103, 32'h0, 32'h80112233, 0, 0);
        check("lbu_data", fld, 32'h00000080);
        step();

        // sh to upper half with three wait cycles
        do_lsu(OP_SH, 32'h22, 32'h1234ABCD, 32'h0, 3, 0);
        check("sh_addr", fa, 32'h20);
        check("sh_wdata", fwd, 32'hABCDABCD);
        check("sh_wstrb", fst, 4'b1100);
        check("sh_req_cycles", reqc, 4);
        check("sh_latency", lat, 4);
        check("sh_load_kept", fld, 32'h00000080);
        step();

        // misaligned lw, then unsupported add
        do_lsu(OP_LW, 32'h101, 32'h0, 32'h0, 0, 0);
        check("mis_latency", lat, 0);
        check("mis_reqc", reqc, 0);
        check("mis_err", ferr, 1);
        step();
        do_lsu(OP_ADD, 32'h0, 32'h0, 32'h0, 0, 0);
        check("add_latency", lat, 0);
        check("add_err", ferr, 1);
        check("add_load_kept", fld, 32'h00000080);
        step();

        // Reset in the second wait cycle of a sw
        operation = OP_SW; addr = 32'h40; store_data = 32'h55667788; start = 1'b1;
        step();
        start = 1'b0;
        check("rst_sw_req_w1", mem.mem_req, 1);
        step();
        check("rst_sw_req_w2", mem.mem_req, 1);
        rst_n = 1'b0;
        step();
        check("rst_sw_req_dropped", mem.mem_req, 0);
        check("rst_sw_busy", busy, 0);
        rst_n = 1'b1;
        mem.mem_ack = 1'b1;
        done_before = n_done;
        step();
        mem.mem_ack = 1'b0;
        check("rst_sw_late_ack_done", done, 0);
        check("rst_sw_late_ack_busy", busy, 0);
        step();
        check("rst_sw_no_done", n_done - done_before, 0);
        do_lsu(OP_LW, 32'h44, 32'h0, 32'h13579BDF, 1, 0);
        check("post_rst_lw_data", fld, 32'h13579BDF);
        check("post_rst_lw_err", ferr, 0);
        step();

        // start held across a whole lw
        done_before = n_done;
        do_lsu(OP_LW, 32'h80, 32'h0, 32'hCAFEF00D, 0, 1);
        check("hold_reqc", reqc, 1);
        check("hold_data", fld, 32'hCAFEF00D);
        step();
        check("hold_idle_busy", busy, 0);
        check("hold_idle_req", mem.mem_req, 0);
        step();
        check("hold_second_busy", busy, 1);
        check("hold_second_req", mem.mem_req, 1);
        start = 1'b0;
        mem.mem_ack = 1'b1;
        mem.mem_rdata = 32'h0BADC0DE;
        step();
        mem.mem_ack = 1'b0;
        check("hold_second_done", done, 1);
        check("hold_second_data", load_data, 32'h0BADC0DE);
        step();
        check("hold_done_pulses", n_done - done_before, 2);

        // Assorted patterns checked by the model
        vecs[0]  = '{OP_SB,  32'h32, 32'h000000A5, 32'h0,         0};
        vecs[1]  = '{OP_SH,  32'h10, 32'hFFFF1357, 32'h0,         1};
        vecs[2]  = '{OP_SW,  32'h24, 32'h89ABCDEF, 32'h0,         2};
        vecs[3]  = '{OP_LH,  32'h06, 32'h0,        32'h80017FFF,  0};
        vecs[4]  = '{OP_LHU, 32'h06, 32'h0,        32'h80017FFF,  1};
        vecs[5]  = '{OP_LB,  32'h01, 32'h0,        32'h00007F00,  0};
        vecs[6]  = '{OP_LH,  32'h03, 32'h0,        32'h0,         0};
        vecs[7]  = '{OP_SW,  32'h02, 32'h1,        32'h0,         0};
        vecs[8]  = '{{2'b00, 3'b011, OPC_L}, 32'h08, 32'h0, 32'h0, 0};
        vecs[9]  = '{{2'b00, 3'b100, OPC_S}, 32'h08, 32'h0, 32'h0, 0};
        vecs[10] = '{{2'b11, 3'b010, OPC_L}, 32'h08, 32'h0, 32'h11223344, 2};
        vecs[11] = '{OP_SH,  32'h01, 32'h0,        32'h0,         0};
        foreach (vecs[i]) begin
            do_lsu(vecs[i].op, vecs[i].a, vecs[i].sd, vecs[i].rd, vecs[i].waits, 0);
            step();
        end
        check("lh_sign_literal_kept", load_data, 32'h11223344);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
